uart_rx_pkt_ctrl: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tick_timeout.sv | 32 +++
 rtl/uart_rx_pkt_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        PAYLOAD,
        CSUM
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEFAULT_SOF_BYTE = 8'h55;

endpackage

// File: rtl/uart_tick_timeout.sv
// Inter-byte watchdog: counts enabled TICK pulses and flags the one that
// completes TIMEOUT_TICKS. The counter wraps to zero on that tick.
module uart_tick_timeout #(
    parameter int TIMEOUT_TICKS = 320,
    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1)
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic terminal
);

    logic [CNT_W-1:0] count_reg;

    // Terminal ignores clear; the caller gives a same-cycle byte priority.
    assign terminal = enable && tick && (count_reg == CNT_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (enable && tick) begin
            if (terminal) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames the uart_rx byte stream into SOF/CMD/LEN/payload/checksum packets,
// streams payload bytes out and reports accept, checksum/length/timeout errors.
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int                   DATA_BITS     = 8,
    parameter logic [DATA_BITS-1:0] SOF_BYTE      = DATA_BITS'(DEFAULT_SOF_BYTE),
    parameter int                   MAX_LEN       = 16,
    parameter int                   TIMEOUT_TICKS = 320,
    parameter int                   IDX_W         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TICK,
    input  logic                 RX_DRDY,
    input  logic [DATA_BITS-1:0] RX_DO,
    output logic                 WR_EN,
    output logic [IDX_W-1:0]     WR_IDX,
    output logic [DATA_BITS-1:0] WR_DATA,
    output logic                 PKT_VALID,
    output logic [DATA_BITS-1:0] PKT_CMD,
    output logic [7:0]           PKT_LEN,
    output logic                 PKT_ERR,
    output logic [1:0]           ERR_CODE,
    output logic                 BUSY
);

    state_t               state_reg, state_next;
    logic [7:0]           acc_reg, acc_next;
    logic [DATA_BITS-1:0] cmd_shadow_reg, cmd_shadow_next;
    logic [7:0]           len_shadow_reg, len_shadow_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 wr_en_reg, wr_en_next;
    logic [IDX_W-1:0]     wr_idx_reg, wr_idx_next;
    logic [DATA_BITS-1:0] wr_data_reg, wr_data_next;
    logic                 pkt_valid_reg, pkt_valid_next;
    logic [DATA_BITS-1:0] pkt_cmd_reg, pkt_cmd_next;
    logic [7:0]           pkt_len_reg, pkt_len_next;
    logic                 pkt_err_reg, pkt_err_next;
    logic [1:0]           err_code_reg, err_code_next;

    logic [7:0] rx_byte;
    logic [7:0] acc_sum;
    logic       timeout_hit;

    assign rx_byte = 8'(RX_DO);
    assign acc_sum = acc_reg + rx_byte;

    uart_tick_timeout #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timeout (
        .clk      (CLK),
        .srst     (RST),
        .clear    (RX_DRDY || (state_reg == IDLE)),
        .enable   (state_reg != IDLE),
        .tick     (TICK),
        .terminal (timeout_hit)
    );

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        cmd_shadow_next = cmd_shadow_reg;
        len_shadow_next = len_shadow_reg;
        idx_next        = idx_reg;
        wr_en_next      = 1'b0;
        wr_idx_next     = wr_idx_reg;
        wr_data_next    = wr_data_reg;
        pkt_valid_next  = 1'b0;
        pkt_cmd_next    = pkt_cmd_reg;
        pkt_len_next    = pkt_len_reg;
        pkt_err_next    = 1'b0;
        err_code_next   = err_code_reg;

        if (RX_DRDY) begin
            unique case (state_reg)
                IDLE: begin
                    if (RX_DO == SOF_BYTE) begin
                        state_next = CMD;
                        acc_next   = 8'd0;
                    end
                end
                CMD: begin
                    cmd_shadow_next = RX_DO;
                    acc_next        = rx_byte;
                    state_next      = LEN;
                end
                LEN: begin
                    acc_next        = acc_sum;
                    len_shadow_next = rx_byte;
                    idx_next        = '0;
                    if (rx_byte > 8'(MAX_LEN)) begin
                        pkt_err_next  = 1'b1;
                        err_code_next = ERR_LEN;
                        state_next    = IDLE;
                    end else if (rx_byte == 8'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    wr_en_next   = 1'b1;
                    wr_idx_next  = idx_reg;
                    wr_data_next = RX_DO;
                    acc_next     = acc_sum;
                    // Hold idx on the last byte so it never passes MAX_LEN-1.
                    if (8'(idx_reg) + 8'd1 == len_shadow_reg) begin
                        state_next = CSUM;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
                CSUM: begin
                    if (acc_sum == 8'd0) begin
                        pkt_valid_next = 1'b1;
                        pkt_cmd_next   = cmd_shadow_reg;
                        pkt_len_next   = len_shadow_reg;
                    end else begin
                        pkt_err_next  = 1'b1;
                        err_code_next = ERR_CSUM;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout_hit) begin
            pkt_err_next  = 1'b1;
            err_code_next = ERR_TIMEOUT;
            state_next    = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            cmd_shadow_reg <= '0;
            len_shadow_reg <= '0;
            idx_reg        <= '0;
            wr_en_reg      <= 1'b0;
            wr_idx_reg     <= '0;
            wr_data_reg    <= '0;
            pkt_valid_reg  <= 1'b0;
            pkt_cmd_reg    <= '0;
            pkt_len_reg    <= '0;
            pkt_err_reg    <= 1'b0;
            err_code_reg   <= ERR_NONE;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            cmd_shadow_reg <= cmd_shadow_next;
            len_shadow_reg <= len_shadow_next;
            idx_reg        <= idx_next;
            wr_en_reg      <= wr_en_next;
            wr_idx_reg     <= wr_idx_next;
            wr_data_reg    <= wr_data_next;
            pkt_valid_reg  <= pkt_valid_next;
            pkt_cmd_reg    <= pkt_cmd_next;
            pkt_len_reg    <= pkt_len_next;
            pkt_err_reg    <= pkt_err_next;
            err_code_reg   <= err_code_next;
        end
    end

    assign WR_EN     = wr_en_reg;
    assign WR_IDX    = wr_idx_reg;
    assign WR_DATA   = wr_data_reg;
    assign PKT_VALID = pkt_valid_reg;
    assign PKT_CMD   = pkt_cmd_reg;
    assign PKT_LEN   = pkt_len_reg;
    assign PKT_ERR   = pkt_err_reg;
    assign ERR_CODE  = err_code_reg;
    assign BUSY      = (state_reg != IDLE);

endmodule
